// File: rtl/jump_pkg.sv
// jump_pkg -- shared definitions for the man_jump_physics block.
//   state_t      : FSM encoding (S_IDLE = 0, S_AIR = 1, S_DONE = 2)
//   Y_W / V_W    : height (unsigned) and velocity (signed) widths
//   GRAVITY_DEF  : default velocity decrement per frame tick
//   H_SPEED_DEF  : default horizontal advance per frame tick
//   sat_add_dist : saturating distance accumulator helper
`timescale 1ns/1ps
package jump_pkg;

  localparam int Y_W = 16;
  localparam int V_W = 9;

  localparam int unsigned GRAVITY_DEF = 1;
  localparam int unsigned H_SPEED_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AIR  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Adds a 4-bit increment to the distance, clamping at all-ones.
  function automatic logic [Y_W-1:0] sat_add_dist(input logic [Y_W-1:0] a,
                                                  input logic [3:0]     inc);
    logic [Y_W:0] sum;
    sum = {1'b0, a} + {{(Y_W + 1 - 4){1'b0}}, inc};
    if (sum[Y_W]) begin
      return {Y_W{1'b1}};
    end else begin
      return sum[Y_W-1:0];
    end
  endfunction

endpackage

// File: rtl/man_jump_integrator.sv
// man_jump_integrator -- combinational vertical-motion datapath.
//   i_y      : current height (unsigned, Y_W bits)
//   i_v      : current vertical velocity (signed, V_W bits)
//   o_y_next : y + v, low Y_W bits (only meaningful when o_land is low)
//   o_v_next : v - GRAVITY
//   o_land   : v <= 0 and y + v <= 0, evaluated on the full 17-bit signed sum
`timescale 1ns/1ps
module man_jump_integrator
  import jump_pkg::*;
#(
  parameter int unsigned GRAVITY = GRAVITY_DEF
) (
  input  logic        [Y_W-1:0] i_y,
  input  logic signed [V_W-1:0] i_v,
  output logic        [Y_W-1:0] o_y_next,
  output logic signed [V_W-1:0] o_v_next,
  output logic                  o_land
);

  localparam logic signed [V_W-1:0] G_V = V_W'(GRAVITY);

  logic signed [Y_W:0] w_y_ext;
  logic signed [Y_W:0] w_v_ext;
  logic signed [Y_W:0] w_sum;
  logic                w_v_nonpos;
  logic                w_sum_nonpos;

  assign w_y_ext  = $signed({1'b0, i_y});
  assign w_v_ext  = $signed({{(Y_W + 1 - V_W){i_v[V_W-1]}}, i_v});
  assign w_sum    = w_y_ext + w_v_ext;

  // Sign-bit tests avoid mixing signed/unsigned relational operators.
  assign w_v_nonpos   = i_v[V_W-1] | (i_v == {V_W{1'b0}});
  assign w_sum_nonpos = w_sum[Y_W] | (w_sum == {(Y_W + 1){1'b0}});

  assign o_y_next = w_sum[Y_W-1:0];
  assign o_v_next = i_v - G_V;
  assign o_land   = w_v_nonpos & w_sum_nonpos;

endmodule

// File: rtl/man_jump_physics.sv
// man_jump_physics -- frame-ticked jump trajectory (height, distance, peak).
//   clk_machine    : 25 MHz clock
//   rst_machine_n  : asynchronous active-low reset
//   i_frame_tick   : one-cycle pulse per display frame
//   i_launch       : one-cycle jump request (only honoured in S_IDLE)
//   i_jump_v_init  : unsigned initial vertical velocity, sampled on launch
//   o_height       : height above ground (registered y)
//   o_dist         : horizontal distance of current/last jump, saturating
//   o_airborne     : high while in S_AIR
//   o_jump_done    : one-cycle landing pulse (the S_DONE cycle)
//   o_peak         : max height of current/last jump
// Optional feature macro: MAN_JUMP_PEAK_EN enables the peak tracker; without
// it o_peak is tied to zero and no peak register exists.
`timescale 1ns/1ps
module man_jump_physics
  import jump_pkg::*;
#(
  parameter int unsigned GRAVITY = GRAVITY_DEF,
  parameter int unsigned H_SPEED = H_SPEED_DEF
) (
  input  logic           clk_machine,
  input  logic           rst_machine_n,
  input  logic           i_frame_tick,
  input  logic           i_launch,
  input  logic [7:0]     i_jump_v_init,
  output logic [Y_W-1:0] o_height,
  output logic [Y_W-1:0] o_dist,
  output logic           o_airborne,
  output logic           o_jump_done,
  output logic [Y_W-1:0] o_peak
);

  localparam logic [3:0] H_INC = 4'(H_SPEED);

  state_t                r_state;
  state_t                w_state_next;
  logic        [Y_W-1:0] r_y;
  logic        [Y_W-1:0] w_y_next;
  logic signed [V_W-1:0] r_v;
  logic signed [V_W-1:0] w_v_next;
  logic        [Y_W-1:0] r_dist;
  logic        [Y_W-1:0] w_dist_next;
  logic                  r_airborne;
  logic                  r_done;

  logic        [Y_W-1:0] w_int_y_next;
  logic signed [V_W-1:0] w_int_v_next;
  logic                  w_land;
  logic                  w_launch_ok;
  logic                  w_tick_air;

  man_jump_integrator #(
    .GRAVITY (GRAVITY)
  ) u_integrator (
    .i_y      (r_y),
    .i_v      (r_v),
    .o_y_next (w_int_y_next),
    .o_v_next (w_int_v_next),
    .o_land   (w_land)
  );

  assign w_launch_ok = (r_state == S_IDLE) & i_launch;
  assign w_tick_air  = (r_state == S_AIR) & i_frame_tick;

  // Next-state and datapath update; a tick in the launch cycle is ignored
  // because integration only happens in S_AIR.
  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_v_next     = r_v;
    w_dist_next  = r_dist;
    case (r_state)
      S_IDLE: begin
        if (i_launch) begin
          w_state_next = S_AIR;
          w_v_next     = $signed({1'b0, i_jump_v_init});
          w_y_next     = {Y_W{1'b0}};
          w_dist_next  = {Y_W{1'b0}};
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_AIR: begin
        if (i_frame_tick) begin
          w_dist_next = sat_add_dist(r_dist, H_INC);
          if (w_land) begin
            w_y_next     = {Y_W{1'b0}};
            w_state_next = S_DONE;
          end else begin
            w_y_next = w_int_y_next;
            w_v_next = w_int_v_next;
          end
        end else begin
          w_state_next = S_AIR;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags derived from the next state.
  always_ff @(posedge clk_machine or negedge rst_machine_n) begin
    if (!rst_machine_n) begin
      r_state    <= S_IDLE;
      r_y        <= {Y_W{1'b0}};
      r_v        <= {V_W{1'b0}};
      r_dist     <= {Y_W{1'b0}};
      r_airborne <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_y        <= w_y_next;
      r_v        <= w_v_next;
      r_dist     <= w_dist_next;
      r_airborne <= (w_state_next == S_AIR);
      r_done     <= (w_state_next == S_DONE);
    end
  end

`ifdef MAN_JUMP_PEAK_EN
  logic [Y_W-1:0] r_peak;
  logic [Y_W-1:0] w_peak_next;

  // Peak tracker: on non-landing ticks y_next is strictly positive, so an
  // unsigned compare of the low bits is exact.
  always_comb begin
    w_peak_next = r_peak;
    if (w_launch_ok) begin
      w_peak_next = {Y_W{1'b0}};
    end else if (w_tick_air && !w_land && (w_int_y_next > r_peak)) begin
      w_peak_next = w_int_y_next;
    end else begin
      w_peak_next = r_peak;
    end
  end

  // Peak register.
  always_ff @(posedge clk_machine or negedge rst_machine_n) begin
    if (!rst_machine_n) begin
      r_peak <= {Y_W{1'b0}};
    end else begin
      r_peak <= w_peak_next;
    end
  end

  assign o_peak = r_peak;
`else
  assign o_peak = {Y_W{1'b0}};
`endif

  assign o_height    = r_y;
  assign o_dist      = r_dist;
  assign o_airborne  = r_airborne;
  assign o_jump_done = r_done;

endmodule

// File: tb/tb_man_jump_physics.sv
`timescale 1ns/1ps
module tb_man_jump_physics;

`ifdef MAN_JUMP_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk_machine = 1'b0;
  logic        rst_machine_n;
  logic        i_frame_tick;
  logic        i_launch;
  logic [7:0]  i_jump_v_init;
  logic [15:0] o_height;
  logic [15:0] o_dist;
  logic        o_airborne;
  logic        o_jump_done;
  logic [15:0] o_peak;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t exp_q[$];

  man_jump_physics dut (
    .clk_machine   (clk_machine),
    .rst_machine_n (rst_machine_n),
    .i_frame_tick  (i_frame_tick),
    .i_launch      (i_launch),
    .i_jump_v_init (i_jump_v_init),
    .o_height      (o_height),
    .o_dist        (o_dist),
    .o_airborne    (o_airborne),
    .o_jump_done   (o_jump_done),
    .o_peak        (o_peak)
  );

  always #20 clk_machine = ~clk_machine;

  always @(posedge clk_machine) begin
    if (o_jump_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic tick, input logic launch, input logic [7:0] vin);
    @(negedge clk_machine);
    i_frame_tick  = tick;
    i_launch      = launch;
    i_jump_v_init = vin;
    @(posedge clk_machine);
    #1;
    i_frame_tick = 1'b0;
    i_launch     = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick_chk(input string tag);
    exp_t e;
    cyc(1'b1, 1'b0, 8'd0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, o_height, e.val);
    end
  endtask

  // Expected v_init = 3 trajectory (GRAVITY 1): 3 5 6 6 5 3 0.
  task automatic push_trace3(input string pfx, input int n);
    logic [15:0] tr [7];
    tr = '{16'd3, 16'd5, 16'd6, 16'd6, 16'd5, 16'd3, 16'd0};
    for (int i = 0; i < n; i++) push_exp({pfx, " height"}, tr[i]);
  endtask

  // Seven ticks of a v_init = 3 jump; with disturb, a launch is asserted in
  // every gap cycle (including the S_DONE cycle) and must be ignored.
  task automatic run_trace(input string pfx, input bit disturb);
    push_trace3(pfx, 7);
    for (int i = 0; i < 7; i++) begin
      tick_chk(pfx);
      chk({pfx, " done@tick"}, {15'd0, o_jump_done}, (i == 6) ? 16'd1 : 16'd0);
      chk({pfx, " air@tick"}, {15'd0, o_airborne}, (i == 6) ? 16'd0 : 16'd1);
      cyc(1'b0, disturb, 8'd200);
      chk({pfx, " done@gap"}, {15'd0, o_jump_done}, 16'd0);
      chk({pfx, " air@gap"}, {15'd0, o_airborne}, (i == 6) ? 16'd0 : 16'd1);
    end
    chk({pfx, " dist"}, o_dist, 16'd14);
    chk({pfx, " peak"}, o_peak, PEAK_EN ? 16'd6 : 16'd0);
    chk({pfx, " height idle"}, o_height, 16'd0);
  endtask

  initial begin
    int my_y, my_v, yn, m_dist, m_peak, n_ticks, max_h;
    bit landed;

    rst_machine_n = 1'b0;
    i_frame_tick  = 1'b0;
    i_launch      = 1'b0;
    i_jump_v_init = 8'd0;
    repeat (2) @(posedge clk_machine);
    #1;
    chk("reset height", o_height, 16'd0);
    chk("reset dist", o_dist, 16'd0);
    chk("reset peak", o_peak, 16'd0);
    chk("reset airborne", {15'd0, o_airborne}, 16'd0);
    chk("reset done", {15'd0, o_jump_done}, 16'd0);
    @(negedge clk_machine);
    rst_machine_n = 1'b1;

    // A: launch on first cycle after reset release, basic v_init = 3 trace.
    cyc(1'b0, 1'b1, 8'd3);
    chk("A air@launch", {15'd0, o_airborne}, 16'd1);
    chk("A height@launch", o_height, 16'd0);
    chk("A dist@launch", o_dist, 16'd0);
    run_trace("A", 1'b0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("A dist held", o_dist, 16'd14);
    chk("A peak held", o_peak, PEAK_EN ? 16'd6 : 16'd0);
    chk("A done count", 16'(done_cnt), 16'd1);

    // B: v_init = 0 lands on the first tick.
    cyc(1'b0, 1'b1, 8'd0);
    push_exp("B height", 16'd0);
    tick_chk("B");
    chk("B done", {15'd0, o_jump_done}, 16'd1);
    chk("B dist", o_dist, 16'd2);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("B done count", 16'(done_cnt), 16'd2);

    // C: tick coincident with launch is ignored.
    cyc(1'b1, 1'b1, 8'd3);
    chk("C height@launch", o_height, 16'd0);
    chk("C dist@launch", o_dist, 16'd0);
    run_trace("C", 1'b0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("C done count", 16'(done_cnt), 16'd3);

    // D: launches while airborne and during S_DONE are ignored.
    cyc(1'b0, 1'b1, 8'd3);
    run_trace("D", 1'b1);
    cyc(1'b0, 1'b0, 8'd0);
    chk("D air after", {15'd0, o_airborne}, 16'd0);
    chk("D done count", 16'(done_cnt), 16'd4);

    // E: asynchronous reset at tick 3 aborts without a done pulse.
    cyc(1'b0, 1'b1, 8'd3);
    push_trace3("E1", 3);
    for (int i = 0; i < 3; i++) tick_chk("E1");
    @(negedge clk_machine);
    rst_machine_n = 1'b0;
    #1;
    chk("E rst height", o_height, 16'd0);
    chk("E rst dist", o_dist, 16'd0);
    chk("E rst peak", o_peak, 16'd0);
    chk("E rst airborne", {15'd0, o_airborne}, 16'd0);
    chk("E rst done", {15'd0, o_jump_done}, 16'd0);
    repeat (2) @(posedge clk_machine);
    #1;
    chk("E rst done held", {15'd0, o_jump_done}, 16'd0);
    @(negedge clk_machine);
    rst_machine_n = 1'b1;
    chk("E done count", 16'(done_cnt), 16'd4);
    cyc(1'b0, 1'b1, 8'd3);
    chk("E2 air@launch", {15'd0, o_airborne}, 16'd1);
    run_trace("E2", 1'b0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("E2 done count", 16'(done_cnt), 16'd5);

    // F: v_init = 255, ticks every cycle, reference trajectory in the bench.
    cyc(1'b0, 1'b1, 8'd255);
    my_y = 0; my_v = 255; m_dist = 0; m_peak = 0;
    n_ticks = 0; max_h = 0; landed = 1'b0;
    while (!landed && n_ticks < 600) begin
      yn = my_y + my_v;
      if (my_v <= 0 && yn <= 0) begin
        my_y   = 0;
        landed = 1'b1;
      end else begin
        if (yn > m_peak) m_peak = yn;
        my_y = yn;
        my_v = my_v - 1;
      end
      m_dist = (m_dist + 2 > 65535) ? 65535 : m_dist + 2;
      push_exp("F height", 16'(my_y));
      tick_chk("F");
      if (int'(o_height) > max_h) max_h = int'(o_height);
      n_ticks++;
    end
    chk("F done", {15'd0, o_jump_done}, 16'd1);
    chk("F ticks", 16'(n_ticks), 16'd511);
    chk("F dist", o_dist, 16'd1022);
    chk("F dist model", o_dist, 16'(m_dist));
    chk("F max height", 16'(max_h), 16'd32640);
    chk("F peak", o_peak, PEAK_EN ? 16'd32640 : 16'd0);
    cyc(1'b0, 1'b0, 8'd0);
    chk("F done count", 16'(done_cnt), 16'd6);
    chk("queue empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
